exec_scheduler: RTL and testbench

Instruction-issue scheduler for the pushbutton CPU. It owns the execution strobe (`Go`) that the CPU core consumes once per instruction. It also sequences run, halt, single-step and breakpoint modes, replacing the CPU's free-running 250 ms counter and turbo gating. It sits between the synchronised/edge-detected front-panel controls and the CPU core, and observes the CPU's `IP` for breakpoint matching.

---
 rtl/exec_sched_pkg.sv | 14 +
 rtl/exec_scheduler_tick_divider.sv | 27 ++
 rtl/exec_scheduler.sv | 106 ++++++++++
 tb/tb_exec_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_sched_pkg.sv
// Shared types and defaults for the pushbutton CPU issue scheduler.
package exec_sched_pkg;

   typedef enum logic [1:0] {
      ST_HALT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_BREAK = 2'd3
   } sched_state_e;

   localparam int          CNT_W_DEF   = 24;
   localparam logic [23:0] CNT_MAX_DEF = 24'd12500000;

endpackage

// File: rtl/exec_scheduler_tick_divider.sv
// Free-running issue-rate divider; tick is high for one cycle per period.
module tick_divider #(
   parameter int               CNT_W   = 24,
   parameter logic [CNT_W-1:0] CNT_MAX = '1
) (
   input  logic Clk,
   input  logic Reset_n,
   output logic tick
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_wrap;

   assign w_wrap = (r_cnt == CNT_MAX);
   assign tick   = w_wrap;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_cnt <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/exec_scheduler.sv
// Issue scheduler: owns the CPU Go strobe and run/halt/step/break modes.
module exec_scheduler
   import exec_sched_pkg::*;
#(
   parameter logic [23:0] CNT_MAX   = CNT_MAX_DEF,
   parameter int          CNT_W     = CNT_W_DEF,
   parameter bit          START_RUN = 1'b1
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        Turbo,
   input  logic        RunReq,
   input  logic        HaltReq,
   input  logic        StepReq,
   input  logic        BkptEn,
   input  logic [7:0]  BkptAddr,
   input  logic [7:0]  IP,
   output logic        Go,
   output logic [1:0]  State,
   output logic        Halted,
   output logic [15:0] InstrCnt
);

   localparam sched_state_e RST_ST = START_RUN ? ST_RUN : ST_HALT;

   sched_state_e r_state;
   sched_state_e w_nxt;
   logic         r_skip;
   logic         w_skip_nxt;
   logic [15:0]  r_icnt;
   logic         w_tick;
   logic         w_hit;
   logic         w_issue;
   logic         w_go;

   tick_divider #(
      .CNT_W   (CNT_W),
      .CNT_MAX (CNT_W'(CNT_MAX))
   ) u_div (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .tick    (w_tick)
   );

   assign w_hit   = BkptEn & (IP == BkptAddr) & ~r_skip;
   assign w_issue = w_tick | Turbo;

   // Requests never reach Go; they only steer the next state.
   assign w_go = Reset_n &
                 (((r_state == ST_RUN) & w_issue & ~w_hit) |
                  (r_state == ST_STEP));

   always_comb begin
      w_nxt      = r_state;
      w_skip_nxt = r_skip;
      unique case (r_state)
         ST_RUN: begin
            if (HaltReq) begin
               w_nxt = ST_HALT;
            end else if (w_issue & w_hit) begin
               w_nxt = ST_BREAK;
            end
            if (w_go) begin
               w_skip_nxt = 1'b0;
            end
         end
         ST_HALT, ST_BREAK: begin
            if (HaltReq & (r_state == ST_BREAK)) begin
               w_nxt = ST_HALT;
            end else if (StepReq) begin
               w_nxt = ST_STEP;
            end else if (RunReq) begin
               w_nxt      = ST_RUN;
               w_skip_nxt = 1'b1;
            end
         end
         ST_STEP: begin
            w_nxt = ST_HALT;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_state <= RST_ST;
         r_skip  <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_skip  <= w_skip_nxt;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_icnt <= '0;
      end else if (w_go && (r_icnt != 16'hFFFF)) begin
         r_icnt <= r_icnt + 16'd1;
      end
   end

   assign Go       = w_go;
   assign State    = r_state;
   assign Halted   = (r_state == ST_HALT) | (r_state == ST_BREAK);
   assign InstrCnt = r_icnt;

endmodule

// File: tb/tb_exec_scheduler.sv
// Directed self-checking bench for exec_scheduler with a 4-cycle tick.
module tb_exec_scheduler;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        Turbo;
   logic        RunReq;
   logic        HaltReq;
   logic        StepReq;
   logic        BkptEn;
   logic [7:0]  BkptAddr;
   logic [7:0]  ip;
   logic        Go;
   logic [1:0]  State;
   logic        Halted;
   logic [15:0] InstrCnt;
   logic        ip_clr;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 Clk = ~Clk;

   // CPU model: IP advances on each edge where Go is high.
   always @(posedge Clk) begin
      if (ip_clr) ip <= 8'd0;
      else if (Go) ip <= ip + 8'd1;
   end

   exec_scheduler #(
      .CNT_MAX   (24'd3),
      .CNT_W     (24),
      .START_RUN (1'b1)
   ) dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .Turbo    (Turbo),
      .RunReq   (RunReq),
      .HaltReq  (HaltReq),
      .StepReq  (StepReq),
      .BkptEn   (BkptEn),
      .BkptAddr (BkptAddr),
      .IP       (ip),
      .Go       (Go),
      .State    (State),
      .Halted   (Halted),
      .InstrCnt (InstrCnt)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      int n;
      Reset_n  = 1'b0;
      Turbo    = 1'b0;
      RunReq   = 1'b0;
      HaltReq  = 1'b0;
      StepReq  = 1'b0;
      BkptEn   = 1'b0;
      BkptAddr = 8'd0;
      ip_clr   = 1'b1;
      step();
      step();
      ip_clr = 1'b0;
      chk("rst_state", State, 32'd1);
      chk("rst_go", Go, 32'd0);
      chk("rst_icnt", InstrCnt, 32'd0);
      chk("rst_halted", Halted, 32'd0);

      // Release: Go on cycles 4, 8, 12.
      Reset_n = 1'b1;
      #1;
      for (int c = 1; c <= 12; c++) begin
         chk($sformatf("run_go_c%0d", c), Go, (c % 4 == 0) ? 32'd1 : 32'd0);
         step();
      end
      chk("run_icnt", InstrCnt, 32'd3);
      chk("run_ip", ip, 32'd3);

      // Turbo into breakpoint at 5.
      ip_clr = 1'b1;
      step();
      ip_clr   = 1'b0;
      Turbo    = 1'b1;
      BkptEn   = 1'b1;
      BkptAddr = 8'd5;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("trb_ip%0d", k), ip, k);
         chk($sformatf("trb_go%0d", k), Go, 32'd1);
         step();
      end
      chk("bk_ip", ip, 32'd5);
      chk("bk_go", Go, 32'd0);
      step();
      chk("bk_state", State, 32'd3);
      chk("bk_halted", Halted, 32'd1);
      chk("bk_icnt", InstrCnt, 32'd8);
      chk("bk_hold_go", Go, 32'd0);

      // Resume past the breakpoint, then trap on revisit.
      RunReq = 1'b1;
      #1;
      chk("rr_nogo", Go, 32'd0);
      step();
      RunReq = 1'b0;
      #1;
      chk("rs_state", State, 32'd1);
      chk("rs_go5", Go, 32'd1);
      step();
      chk("rs_ip6", ip, 32'd6);
      chk("rs_go6", Go, 32'd1);
      n = 0;
      while (!Halted && n < 400) begin
         step();
         n++;
      end
      chk("rv_timeout", (n < 400) ? 32'd1 : 32'd0, 32'd1);
      chk("rv_state", State, 32'd3);
      chk("rv_ip", ip, 32'd5);
      chk("rv_icnt", InstrCnt, 32'd264);

      // BREAK -> HALT, then single step.
      HaltReq = 1'b1;
      step();
      HaltReq = 1'b0;
      #1;
      chk("h_state", State, 32'd0);
      StepReq = 1'b1;
      #1;
      chk("st_req_go", Go, 32'd0);
      step();
      StepReq = 1'b0;
      #1;
      chk("st_state", State, 32'd2);
      chk("st_go", Go, 32'd1);
      step();
      chk("st_back", State, 32'd0);
      chk("st_ip", ip, 32'd6);
      chk("st_go_off", Go, 32'd0);
      chk("st_icnt", InstrCnt, 32'd265);

      // Step + Run together: step wins.
      StepReq = 1'b1;
      RunReq  = 1'b1;
      step();
      StepReq = 1'b0;
      RunReq  = 1'b0;
      #1;
      chk("sr_state", State, 32'd2);
      step();
      chk("sr_back", State, 32'd0);
      chk("sr_icnt", InstrCnt, 32'd266);
      chk("sr_ip", ip, 32'd7);

      // Halt arriving just before a tick cycle.
      Turbo  = 1'b0;
      BkptEn = 1'b0;
      RunReq = 1'b1;
      step();
      RunReq = 1'b0;
      #1;
      n = 0;
      while (!Go && n < 20) begin
         step();
         n++;
      end
      chk("tk_timeout", Go, 32'd1);
      step();
      step();
      step();
      HaltReq = 1'b1;
      #1;
      chk("hq_go", Go, 32'd0);
      step();
      HaltReq = 1'b0;
      #1;
      chk("hq_tick_go", Go, 32'd0);
      chk("hq_state", State, 32'd0);
      chk("hq_icnt", InstrCnt, 32'd267);
      chk("hq_ip", ip, 32'd8);

      // Reset during STEP aborts it.
      StepReq = 1'b1;
      step();
      StepReq = 1'b0;
      #1;
      chk("rs_step_state", State, 32'd2);
      Reset_n = 1'b0;
      #1;
      chk("rs_step_go", Go, 32'd0);
      step();
      chk("rs_step_st", State, 32'd1);
      chk("rs_step_icnt", InstrCnt, 32'd0);
      chk("rs_step_ip", ip, 32'd8);

      // Saturation in turbo.
      Turbo   = 1'b1;
      Reset_n = 1'b1;
      #1;
      chk("sat_go", Go, 32'd1);
      for (int i = 0; i < 65534; i++) step();
      chk("sat_fffe", InstrCnt, 32'hFFFE);
      step();
      chk("sat_ffff", InstrCnt, 32'hFFFF);
      step();
      step();
      step();
      chk("sat_hold", InstrCnt, 32'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
